// File: rtl/tmds_channel_decoder.sv
// One TMDS receive channel: finds 10-bit symbol alignment by hunting for
// control tokens, then decodes each aligned symbol as video, control and TERC4.
module tmds_channel_decoder #(
  parameter int LOCK_COUNT    = 16,
  parameter int SEARCH_WINDOW = 4096
) (
  input  logic       clk_pixel,
  input  logic       reset_n,
  input  logic [9:0] raw_word,
  output logic       locked,
  output logic [3:0] offset,
  output logic [7:0] video_data,
  output logic [1:0] ctrl,
  output logic [3:0] terc4,
  output logic       is_ctrl,
  output logic       is_terc4
);
  localparam int            CW       = $clog2(SEARCH_WINDOW);
  localparam logic [CW-1:0] CNT_LAST = CW'(SEARCH_WINDOW - 1);
  localparam logic [7:0]    RUN_LOCK = 8'(LOCK_COUNT);

  typedef enum logic [1:0] {ST_SEARCH, ST_VERIFY, ST_LOCKED} state_e;

  state_e        state_q, state_d;
  logic [9:0]    prev_q, prev_d;
  logic [9:0]    sym_q, sym_d;
  logic [3:0]    offset_q, offset_d;
  logic          locked_q, locked_d;
  logic [CW-1:0] win_q, win_d;
  logic [CW-1:0] wd_q, wd_d;
  logic [7:0]    run_q, run_d;
  logic [7:0]    video_q, video_d;
  logic [1:0]    ctrl_q, ctrl_d;
  logic [3:0]    terc4_q, terc4_d;
  logic          is_ctrl_q, is_ctrl_d;
  logic          is_terc4_q, is_terc4_d;

  logic [18:0]   cat;
  logic [7:0]    qbits;
  logic [7:0]    vdec;
  logic [3:0]    offset_slip;
  logic          win_exp;
  logic [7:0]    run_inc;

  // Bit 19 of {raw_word, prev_q} can never fall inside a 10-bit window.
  assign cat = {raw_word[8:0], prev_q};

  always_comb begin
    prev_d = raw_word;
    sym_d  = prev_q;
    for (int i = 1; i < 10; i++) begin
      if (offset_q == 4'(i)) sym_d = cat[i +: 10];
    end
  end

  always_comb begin
    is_ctrl_d = 1'b1;
    ctrl_d    = 2'd0;
    case (sym_q)
      10'b1101010100: ctrl_d = 2'd0;
      10'b0010101011: ctrl_d = 2'd1;
      10'b0101010100: ctrl_d = 2'd2;
      10'b1010101011: ctrl_d = 2'd3;
      default:        is_ctrl_d = 1'b0;
    endcase
  end

  always_comb begin
    is_terc4_d = 1'b1;
    terc4_d    = 4'h0;
    case (sym_q)
      10'b1010011100: terc4_d = 4'h0;
      10'b1001100011: terc4_d = 4'h1;
      10'b1011100100: terc4_d = 4'h2;
      10'b1011100010: terc4_d = 4'h3;
      10'b0101110001: terc4_d = 4'h4;
      10'b0100011110: terc4_d = 4'h5;
      10'b0110001110: terc4_d = 4'h6;
      10'b0100111100: terc4_d = 4'h7;
      10'b1011001100: terc4_d = 4'h8;
      10'b0100111001: terc4_d = 4'h9;
      10'b0110011100: terc4_d = 4'hA;
      10'b1011000110: terc4_d = 4'hB;
      10'b1010001110: terc4_d = 4'hC;
      10'b1001110001: terc4_d = 4'hD;
      10'b0101100011: terc4_d = 4'hE;
      10'b1011000011: terc4_d = 4'hF;
      default:        is_terc4_d = 1'b0;
    endcase
  end

  // sym[9] undoes the DC-balance inversion, sym[8] picks XOR vs XNOR chaining.
  always_comb begin
    qbits   = sym_q[9] ? ~sym_q[7:0] : sym_q[7:0];
    vdec    = 8'h00;
    vdec[0] = qbits[0];
    for (int i = 1; i < 8; i++) begin
      vdec[i] = sym_q[8] ? (qbits[i] ^ qbits[i-1]) : ~(qbits[i] ^ qbits[i-1]);
    end
    video_d = vdec;
  end

  assign offset_slip = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
  assign win_exp     = (win_q == CNT_LAST);
  assign run_inc     = run_q + 8'd1;

  // Alignment FSM judges the registered symbol; window expiry beats everything.
  always_comb begin
    state_d  = state_q;
    offset_d = offset_q;
    locked_d = locked_q;
    win_d    = win_q;
    run_d    = run_q;
    wd_d     = wd_q;
    case (state_q)
      ST_SEARCH: begin
        win_d = win_q + 1'b1;
        if (win_exp) begin
          offset_d = offset_slip;
          win_d    = '0;
          run_d    = 8'd0;
        end else if (is_ctrl_d) begin
          state_d = ST_VERIFY;
          run_d   = 8'd1;
        end
      end
      ST_VERIFY: begin
        win_d = win_q + 1'b1;
        if (win_exp) begin
          state_d  = ST_SEARCH;
          offset_d = offset_slip;
          win_d    = '0;
          run_d    = 8'd0;
        end else if (!is_ctrl_d) begin
          state_d = ST_SEARCH;
          run_d   = 8'd0;
        end else begin
          run_d = run_inc;
          if (run_inc == RUN_LOCK) begin
            state_d  = ST_LOCKED;
            locked_d = 1'b1;
            wd_d     = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (is_ctrl_d) begin
          wd_d = '0;
        end else if (wd_q == CNT_LAST) begin
          state_d  = ST_SEARCH;
          locked_d = 1'b0;
          offset_d = offset_slip;
          win_d    = '0;
          run_d    = 8'd0;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: state_d = ST_SEARCH;
    endcase
  end

  always_ff @(posedge clk_pixel) begin
    if (!reset_n) begin
      state_q    <= ST_SEARCH;
      prev_q     <= '0;
      sym_q      <= '0;
      offset_q   <= '0;
      locked_q   <= 1'b0;
      win_q      <= '0;
      wd_q       <= '0;
      run_q      <= '0;
      video_q    <= '0;
      ctrl_q     <= '0;
      terc4_q    <= '0;
      is_ctrl_q  <= 1'b0;
      is_terc4_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= prev_d;
      sym_q      <= sym_d;
      offset_q   <= offset_d;
      locked_q   <= locked_d;
      win_q      <= win_d;
      wd_q       <= wd_d;
      run_q      <= run_d;
      video_q    <= video_d;
      ctrl_q     <= ctrl_d;
      terc4_q    <= terc4_d;
      is_ctrl_q  <= is_ctrl_d;
      is_terc4_q <= is_terc4_d;
    end
  end

  assign locked     = locked_q;
  assign offset     = offset_q;
  assign video_data = video_q;
  assign ctrl       = ctrl_q;
  assign terc4      = terc4_q;
  assign is_ctrl    = is_ctrl_q;
  assign is_terc4   = is_terc4_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Scoreboard bench: the driver steps a reference model and queues the expected
// outputs; a monitor compares them one cycle at a time.
module tb_tmds_channel_decoder;
  localparam int LC = 16;
  localparam int SW = 64;

  logic       clk_pixel = 1'b0;
  logic       reset_n   = 1'b0;
  logic [9:0] raw_word  = '0;
  logic       locked;
  logic [3:0] offset;
  logic [7:0] video_data;
  logic [1:0] ctrl;
  logic [3:0] terc4;
  logic       is_ctrl;
  logic       is_terc4;

  tmds_channel_decoder #(.LOCK_COUNT(LC), .SEARCH_WINDOW(SW)) dut (
    .clk_pixel (clk_pixel),
    .reset_n   (reset_n),
    .raw_word  (raw_word),
    .locked    (locked),
    .offset    (offset),
    .video_data(video_data),
    .ctrl      (ctrl),
    .terc4     (terc4),
    .is_ctrl   (is_ctrl),
    .is_terc4  (is_terc4)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct packed {
    logic       locked;
    logic [3:0] offset;
    logic [7:0] vd;
    logic [1:0] ctrl;
    logic [3:0] terc;
    logic       isc;
    logic       ist;
  } obs_t;

  obs_t       exp_q[$];
  int         n_chk  = 0;
  int         n_fail = 0;
  logic [9:0] ctrl_tab[4];
  logic [9:0] terc_tab[16];
  logic [7:0] dec_tab[2][256];
  logic [9:0] vid_sym;

  // reference model state
  logic [9:0] m_prev, m_sym;
  int         m_off, m_mode, m_win, m_run, m_wd;
  obs_t       m_out;

  function automatic logic [9:0] tmds_enc(input logic [7:0] d, input logic xm, input logic inv);
    logic [7:0] q;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xm ? (q[i-1] ^ d[i]) : ~(q[i-1] ^ d[i]);
    return {inv, xm, inv ? ~q : q};
  endfunction

  function automatic int find_code(input logic [9:0] s, input bit terc);
    if (terc) begin
      for (int i = 0; i < 16; i++) if (terc_tab[i] == s) return i;
    end else begin
      for (int i = 0; i < 4; i++) if (ctrl_tab[i] == s) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [9:0] raw, input logic rn);
    int         ci, ti;
    logic [19:0] w;
    logic [9:0] nsym;
    logic [7:0] q8;
    obs_t       e;
    if (!rn) begin
      m_prev = '0; m_sym = '0; m_off = 0; m_mode = 0;
      m_win = 0; m_run = 0; m_wd = 0; m_out = '0;
    end else begin
      ci = find_code(m_sym, 1'b0);
      ti = find_code(m_sym, 1'b1);
      q8 = m_sym[9] ? ~m_sym[7:0] : m_sym[7:0];
      e.vd   = dec_tab[m_sym[8]][q8];
      e.isc  = (ci >= 0);
      e.ctrl = (ci >= 0) ? 2'(ci) : 2'd0;
      e.ist  = (ti >= 0);
      e.terc = (ti >= 0) ? 4'(ti) : 4'd0;
      w    = {raw, m_prev};
      nsym = 10'(w >> m_off);
      // mode: 0 hunting, 1 counting a run, 2 aligned
      if (m_mode == 0) begin
        if (m_win == SW - 1) begin
          m_off = (m_off + 1) % 10; m_win = 0; m_run = 0;
        end else begin
          m_win++;
          if (ci >= 0) begin m_mode = 1; m_run = 1; end
        end
      end else if (m_mode == 1) begin
        if (m_win == SW - 1) begin
          m_off = (m_off + 1) % 10; m_win = 0; m_run = 0; m_mode = 0;
        end else if (ci < 0) begin
          m_win++; m_run = 0; m_mode = 0;
        end else begin
          m_win++; m_run++;
          if (m_run == LC) begin m_mode = 2; m_wd = 0; end
        end
      end else begin
        if (ci >= 0) m_wd = 0;
        else if (m_wd == SW - 1) begin
          m_off = (m_off + 1) % 10; m_win = 0; m_run = 0; m_mode = 0;
        end else m_wd++;
      end
      e.locked = (m_mode == 2);
      e.offset = 4'(m_off);
      m_sym  = nsym;
      m_prev = raw;
      m_out  = e;
    end
    exp_q.push_back(m_out);
  endtask

  task automatic cyc(input logic [9:0] w, input logic rn);
    @(negedge clk_pixel);
    raw_word = w;
    reset_n  = rn;
    model_step(w, rn);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor
  initial begin
    forever begin
      obs_t e, a;
      @(posedge clk_pixel);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = {locked, offset, video_data, ctrl, terc4, is_ctrl, is_terc4};
        if (!e.isc) a.ctrl = 2'd0;
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL scoreboard @%0t: got %h expected %h", $time, a, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    n_fail++;
    $display("FAIL timeout: simulation did not finish");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1);
  end

  initial begin
    logic [9:0] e, w, tk;
    int         r, n;
    ctrl_tab = '{10'b1101010100, 10'b0010101011, 10'b0101010100, 10'b1010101011};
    terc_tab = '{10'b1010011100, 10'b1001100011, 10'b1011100100, 10'b1011100010,
                 10'b0101110001, 10'b0100011110, 10'b0110001110, 10'b0100111100,
                 10'b1011001100, 10'b0100111001, 10'b0110011100, 10'b1011000110,
                 10'b1010001110, 10'b1001110001, 10'b0101100011, 10'b1011000011};
    for (int m = 0; m < 2; m++)
      for (int d = 0; d < 256; d++) begin
        e = tmds_enc(8'(d), m[0], 1'b0);
        dec_tab[m][e[7:0]] = 8'(d);
      end
    vid_sym = tmds_enc(8'h00, 1'b1, 1'b0);

    repeat (3) cyc('0, 1'b0);
    repeat (20) cyc(ctrl_tab[0], 1'b1);
    check("lock_off0_locked", locked, 1);
    check("lock_off0_offset", offset, 0);
    check("lock_off0_isctrl", is_ctrl, 1);
    check("lock_off0_ctrl", ctrl, 0);

    cyc(tmds_enc(8'h00, 1'b1, 1'b0), 1'b1);
    cyc(tmds_enc(8'hFF, 1'b0, 1'b1), 1'b1);
    cyc(tmds_enc(8'h10, 1'b1, 1'b1), 1'b1);
    cyc(tmds_enc(8'hA5, 1'b0, 1'b0), 1'b1);
    repeat (3) cyc(ctrl_tab[0], 1'b1);
    check("video_a5", video_data, 8'hA5);
    check("video_isctrl", is_ctrl, 0);

    for (int i = 0; i < 16; i++) cyc(terc_tab[i], 1'b1);
    cyc(10'b1011001100, 1'b1);
    repeat (4) cyc(ctrl_tab[1], 1'b1);

    repeat (2) cyc('0, 1'b0);
    repeat (10) cyc(ctrl_tab[2], 1'b1);
    cyc(vid_sym, 1'b1);
    repeat (3) cyc(ctrl_tab[2], 1'b1);
    check("interrupt_nolock", locked, 0);
    repeat (17) cyc(ctrl_tab[2], 1'b1);
    check("interrupt_locked", locked, 1);
    check("interrupt_offset", offset, 0);

    repeat (SW + 6) cyc(vid_sym, 1'b1);
    check("watchdog_unlock", locked, 0);
    check("watchdog_offset", offset, 1);

    repeat (2) cyc('0, 1'b0);
    repeat (5) cyc(ctrl_tab[3], 1'b1);
    cyc(ctrl_tab[3], 1'b0);
    cyc(ctrl_tab[3], 1'b1);
    check("reset_mid_verify", {locked, offset, video_data, ctrl, terc4, is_ctrl, is_terc4}, 0);

    // serial stream of token 10 with its first bit at stream position 3
    repeat (2) cyc('0, 1'b0);
    tk = ctrl_tab[2];
    for (int t = 0; t < 3 * SW + 30; t++) begin
      for (int b = 0; b < 10; b++) w[b] = tk[(10 * t + b + 7) % 10];
      cyc(w, 1'b1);
    end
    check("slip_offset", offset, 3);
    check("slip_locked", locked, 1);
    check("slip_ctrl", ctrl, 2);

    repeat (2) cyc('0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (i == 200) cyc(10'($urandom), 1'b0);
      else if (r < 2) begin
        n = $urandom_range(12, 20);
        w = ctrl_tab[$urandom_range(0, 3)];
        repeat (n) cyc(w, 1'b1);
      end else if (r < 4) cyc(ctrl_tab[$urandom_range(0, 3)], 1'b1);
      else if (r < 6) cyc(terc_tab[$urandom_range(0, 15)], 1'b1);
      else if (r < 8) cyc(tmds_enc(8'($urandom), 1'($urandom), 1'($urandom)), 1'b1);
      else cyc(10'($urandom), 1'b1);
    end

    repeat (3) @(posedge clk_pixel);
    #2;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tmds_channel_decoder.md
# tmds_channel_decoder

Receive-side decoder for one TMDS channel, the inverse of the HDMI transmitter's per-channel TMDS/TERC4/control encoder. It takes unaligned 10-bit parallel words from an upstream 1:10 deserializer. It finds symbol alignment by hunting for control-period tokens, then decodes every aligned symbol into its video byte, control pair and TERC4 nibble, with classification flags. Three instances, one per data channel, feed the HDMI sink's timing and packet recovery logic.

## Interface

Parameters:
- LOCK_COUNT, 16: consecutive control tokens at one offset required to declare lock (2..255).
- SEARCH_WINDOW, 4096: cycles allowed per offset while searching, and the control-token watchdog length once locked (power of two, 16..65536).

Ports:
- clk_pixel  input  1  pixel clock; all logic on its rising edge.
- reset_n  input  1  synchronous, active-low reset.
- raw_word  input  10  deserialized word; bit 0 is the earliest bit received.
- locked  output  1  alignment achieved.
- offset  output  4  current bit-slip offset, 0..9.
- video_data  output  8  TMDS 8b/10b decode of the current symbol.
- ctrl  output  2  control bits; valid when is_ctrl.
- terc4  output  4  TERC4 nibble; valid when is_terc4.
- is_ctrl  output  1  symbol is one of the 4 control tokens.
- is_terc4  output  1  symbol is one of the 16 TERC4 codes.

## Operation

- Alignment window: prev_q holds the previous raw_word. Symbol = bits [offset+9 : offset] of {raw_word, prev_q}. Offset 0 means prev_q unchanged.
- Control tokens (ctrl=00/01/10/11): 1101010100, 0010101011, 0101010100, 1010101011.
- TERC4 codes 0..F: 1010011100, 1001100011, 1011100100, 1011100010, 0101110001, 0100011110, 0110001110, 0100111100, 1011001100, 0100111001, 0110011100, 1011000110, 1010001110, 1001110001, 0101100011, 1011000011. Codes not in this list give is_terc4=0 and terc4=0.
- Video decode applies to every symbol, including control and TERC4 symbols.
  - q = sym[9] ? ~sym[7:0] : sym[7:0].
  - d[0] = q[0].
  - d[i] = sym[8] ? q[i]^q[i-1] : ~(q[i]^q[i-1]) for i = 1..7.
- Control, TERC4 and video decode are independent. Guard-band and period disambiguation belongs downstream.
- Decode outputs update every cycle regardless of lock.
- State machine (state encoding is internal):
  - SEARCH: win_cnt increments each cycle.
    - Control token seen → VERIFY, run_cnt=1.
    - win_cnt reaches SEARCH_WINDOW-1 → offset = offset==9 ? 0 : offset+1; win_cnt=0; run_cnt=0.
  - VERIFY: win_cnt keeps counting.
    - Control token seen → run_cnt+1.
    - run_cnt reaches LOCK_COUNT → LOCKED, locked=1, wd_cnt=0.
    - Non-control symbol → SEARCH; win_cnt is not reset.
    - Window expiry → slip as in SEARCH, return to SEARCH. Expiry takes priority over reaching LOCK_COUNT in the same cycle.
  - LOCKED: wd_cnt clears on any control token, otherwise increments.
    - wd_cnt reaches SEARCH_WINDOW-1 → SEARCH, locked=0, offset advances by one (wrapping 9→0), win_cnt=0.
- Offset changes only on a slip. The state machine evaluates the registered symbol, so the first symbol after a slip is judged at the new offset.

## Timing

- Reset (reset_n=0 at a rising edge): state SEARCH, offset=0, locked=0, all decode outputs 0, all counters 0, prev_q=0.
- Reset mid-operation drops lock on the next edge with no further outputs.
- Pipeline: edge k registers the aligned symbol into sym_q. Edge k+1 registers the decode outputs from sym_q.
- Latency at offset 0: raw_word sampled at edge k appears on the outputs after edge k+2.
- The state machine acts on sym_q classification. locked rises at the same edge that registers the decode of the LOCK_COUNT-th consecutive control token.
- Slip timing: offset updates at the edge where the window expires. Symbols formed from the next edge onward use the new offset.
- Back-to-back: a token arriving in the same cycle as the VERIFY→SEARCH fallback on a non-control symbol is not counted.

## Test plan

- Offset 0 lock: after reset, drive 20 cycles of 1101010100 → locked=1 after the 16th token is registered. offset=0, is_ctrl=1, ctrl=00.
- Bit-slip search: serial stream of control token 10 repeating, delivered shifted by 3 bits, SEARCH_WINDOW=16 → offset steps 0,1,2,3 every 16 cycles. Lock at offset 3 within 3×16+18 cycles. ctrl=10.
- Video decode: locked, send the TMDS encodings of 0x00, 0xFF, 0x10, 0xA5 → video_data 0x00, 0xFF, 0x10, 0xA5 two cycles later. is_ctrl=0.
- TERC4: send all 16 codes in order → terc4 0..F with is_terc4=1. 1011001100 also gives is_terc4=1, terc4=8.
- Interrupted verify: 10 control tokens, 1 video symbol, then 16 tokens → no lock at token 10. Lock after the second run, offset unchanged.
- Watchdog and reset: locked, then SEARCH_WINDOW cycles of video only → locked=0, offset=1. Assert reset_n=0 mid-VERIFY → all outputs 0 at the next edge.
